// File: rtl/fp_defs_pkg.sv
// Shared float widths and lane/prenorm record types for the adder datapath.
package fp_defs;

   localparam int C_OP           = 16;
   localparam int C_EXP          = 5;
   localparam int C_MANT         = 10;
   // One extra bit each for the add carry and the signed exponent headroom.
   localparam int C_EXP_PRENORM  = C_EXP + 2;
   localparam int C_MANT_PRENORM = C_MANT + 2;

   typedef struct packed {
      logic              sign;
      logic [C_EXP-1:0]  exp;
      logic [C_MANT-1:0] mant;
   } fp_lane_t;

   typedef struct packed {
      logic                             sign;
      logic signed [C_EXP_PRENORM-1:0]  exp;
      logic [C_MANT_PRENORM-1:0]        mant;
   } prenorm_t;

endpackage

// File: rtl/fp_add.sv
// Add core: aligns the smaller operand (truncating shift) and adds or
// subtracts mantissas, producing an unnormalised sign/exponent/mantissa.
module fp_add #(
   parameter int C_EXP          = fp_defs::C_EXP,
   parameter int C_MANT         = fp_defs::C_MANT,
   parameter int C_EXP_PRENORM  = fp_defs::C_EXP_PRENORM,
   parameter int C_MANT_PRENORM = fp_defs::C_MANT_PRENORM
) (
   input  logic                             sign_a,
   input  logic [C_EXP-1:0]                 exp_a,
   input  logic [C_MANT:0]                  mant_a,
   input  logic                             sign_b,
   input  logic [C_EXP-1:0]                 exp_b,
   input  logic [C_MANT:0]                  mant_b,
   output logic                             pre_sign,
   output logic signed [C_EXP_PRENORM-1:0]  pre_exp,
   output logic [C_MANT_PRENORM-1:0]        pre_mant
);

   logic              a_big;
   logic [C_EXP-1:0]  exp_big, exp_small, shift;
   logic [C_MANT:0]   mant_big, mant_small, mant_sh;

   // Order by magnitude so the difference is never negative; ties keep a.
   always_comb begin
      a_big      = {exp_a, mant_a} >= {exp_b, mant_b};
      exp_big    = a_big ? exp_a  : exp_b;
      exp_small  = a_big ? exp_b  : exp_a;
      mant_big   = a_big ? mant_a : mant_b;
      mant_small = a_big ? mant_b : mant_a;
      shift      = exp_big - exp_small;
      mant_sh    = mant_small >> shift;
      pre_sign   = a_big ? sign_a : sign_b;
      pre_exp    = $signed(C_EXP_PRENORM'(exp_big));
      if (sign_a == sign_b)
         pre_mant = C_MANT_PRENORM'(mant_big) + C_MANT_PRENORM'(mant_sh);
      else
         pre_mant = C_MANT_PRENORM'(mant_big) - C_MANT_PRENORM'(mant_sh);
   end

endmodule

// File: rtl/fp_adder_lane.sv
// One lane: unpack, optional b negation, add core, optional prenorm
// register, normaliser and optional result register.
module fp_adder_lane #(
   parameter int C_OP           = fp_defs::C_OP,
   parameter int C_EXP          = fp_defs::C_EXP,
   parameter int C_MANT         = fp_defs::C_MANT,
   parameter int C_EXP_PRENORM  = fp_defs::C_EXP_PRENORM,
   parameter int C_MANT_PRENORM = fp_defs::C_MANT_PRENORM,
   parameter int C_STAGES       = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_pre,
   input  logic            ld_res,
   input  logic            op_sub,
   input  logic [C_OP-1:0] a,
   input  logic [C_OP-1:0] b,
   output logic [C_OP-1:0] result
);

   logic                             sign_a, sign_b;
   logic [C_EXP-1:0]                 exp_a, exp_b;
   logic [C_MANT:0]                  mant_a, mant_b;
   logic                             add_sign, pre_sign;
   logic signed [C_EXP_PRENORM-1:0]  add_exp, pre_exp;
   logic [C_MANT_PRENORM-1:0]        add_mant, pre_mant;
   logic [C_EXP-1:0]                 norm_exp;
   logic [C_MANT-1:0]                norm_mant;
   logic [C_OP-1:0]                  res_comb;

   // A zero exponent clears the hidden bit (zero/denormal).
   assign sign_a = a[C_OP-1];
   assign exp_a  = a[C_OP-2 -: C_EXP];
   assign mant_a = {|exp_a, a[C_MANT-1:0]};
   assign sign_b = b[C_OP-1] ^ op_sub;
   assign exp_b  = b[C_OP-2 -: C_EXP];
   assign mant_b = {|exp_b, b[C_MANT-1:0]};

   fp_add #(.C_EXP(C_EXP), .C_MANT(C_MANT), .C_EXP_PRENORM(C_EXP_PRENORM),
            .C_MANT_PRENORM(C_MANT_PRENORM)) u_add (
      .sign_a(sign_a), .exp_a(exp_a), .mant_a(mant_a),
      .sign_b(sign_b), .exp_b(exp_b), .mant_b(mant_b),
      .pre_sign(add_sign), .pre_exp(add_exp), .pre_mant(add_mant)
   );

   generate
      if (C_STAGES >= 2) begin : g_pre
         // Prenorm register splits add and normalise into separate cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pre_sign <= 1'b0;
               pre_exp  <= '0;
               pre_mant <= '0;
            end else if (ld_pre) begin
               pre_sign <= add_sign;
               pre_exp  <= add_exp;
               pre_mant <= add_mant;
            end
         end
      end else begin : g_pre_bypass
         assign pre_sign = add_sign;
         assign pre_exp  = add_exp;
         assign pre_mant = add_mant;
      end
   endgenerate

   fp_norm #(.C_EXP(C_EXP), .C_MANT(C_MANT), .C_EXP_PRENORM(C_EXP_PRENORM),
             .C_MANT_PRENORM(C_MANT_PRENORM)) u_norm (
      .pre_exp(pre_exp), .pre_mant(pre_mant),
      .norm_exp(norm_exp), .norm_mant(norm_mant)
   );

   assign res_comb = {pre_sign, norm_exp, norm_mant};

   generate
      if (C_STAGES == 3) begin : g_res
         // Final result register isolates the normaliser from the consumer.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      result <= '0;
            else if (ld_res) result <= res_comb;
         end
      end else begin : g_res_bypass
         logic unused_ctrl;
         assign unused_ctrl = ld_res ^ ld_pre ^ clk ^ rst_n;
         assign result      = res_comb;
      end
   endgenerate

endmodule

// File: rtl/fp_norm.sv
// Normaliser: carry right-shift or leading-zero left-shift, then flush
// underflow to zero and saturate overflow to infinity.
module fp_norm #(
   parameter int C_EXP          = fp_defs::C_EXP,
   parameter int C_MANT         = fp_defs::C_MANT,
   parameter int C_EXP_PRENORM  = fp_defs::C_EXP_PRENORM,
   parameter int C_MANT_PRENORM = fp_defs::C_MANT_PRENORM
) (
   input  logic signed [C_EXP_PRENORM-1:0]  pre_exp,
   input  logic [C_MANT_PRENORM-1:0]        pre_mant,
   output logic [C_EXP-1:0]                 norm_exp,
   output logic [C_MANT-1:0]                norm_mant
);

   localparam logic signed [C_EXP_PRENORM-1:0] EXP_MAX = C_EXP_PRENORM'((1 << C_EXP) - 1);
   localparam logic signed [C_EXP_PRENORM-1:0] EXP_ONE = C_EXP_PRENORM'(1);

   int                               lz;
   logic signed [C_EXP_PRENORM-1:0]  e_tmp;
   logic [C_MANT_PRENORM-1:0]        m_tmp;
   logic                             unused_m;

   assign unused_m = ^m_tmp[C_MANT_PRENORM-1:C_MANT];

   // Shift the leading one into the hidden-bit position and fix the exponent.
   always_comb begin
      lz = C_MANT + 1;
      for (int i = 0; i <= C_MANT; i++)
         if (pre_mant[i]) lz = C_MANT - i;
      if (pre_mant[C_MANT+1]) begin
         m_tmp = pre_mant >> 1;
         e_tmp = pre_exp + EXP_ONE;
      end else begin
         m_tmp = pre_mant << lz;
         e_tmp = pre_exp - $signed(C_EXP_PRENORM'(lz));
      end
      if (pre_mant == '0 || e_tmp[C_EXP_PRENORM-1] || e_tmp == '0) begin
         norm_exp  = '0;
         norm_mant = '0;
      end else if (e_tmp >= EXP_MAX) begin
         norm_exp  = '1;
         norm_mant = '0;
      end else begin
         norm_exp  = e_tmp[C_EXP-1:0];
         norm_mant = m_tmp[C_MANT-1:0];
      end
   end

endmodule

// File: rtl/fp_adder_pipe.sv
// Multi-lane pipelined FP add/sub with valid/ready; one global stall enable.
module fp_adder_pipe #(
   parameter int C_OP           = fp_defs::C_OP,
   parameter int C_EXP          = fp_defs::C_EXP,
   parameter int C_MANT         = fp_defs::C_MANT,
   parameter int C_EXP_PRENORM  = fp_defs::C_EXP_PRENORM,
   parameter int C_MANT_PRENORM = fp_defs::C_MANT_PRENORM,
   parameter int C_LANES        = 4,
   parameter int C_STAGES       = 2,
   parameter int C_TAG_W        = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [C_LANES-1:0]        op_sub_i,
   input  logic [C_LANES*C_OP-1:0]   operand_a_i,
   input  logic [C_LANES*C_OP-1:0]   operand_b_i,
   input  logic [C_TAG_W-1:0]        tag_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [C_LANES*C_OP-1:0]   result_o,
   output logic [C_TAG_W-1:0]        tag_o
);

   logic                       en, ld_pre, ld_res;
   logic [C_STAGES-1:0]        vld_pipe;
   logic [C_TAG_W-1:0]         tag_pipe [C_STAGES];
   logic [C_LANES-1:0]         sub_q;
   logic [C_LANES*C_OP-1:0]    a_q, b_q;

   // The whole pipe moves together; a stalled output freezes every stage.
   assign out_valid_o = vld_pipe[C_STAGES-1];
   assign en          = ~out_valid_o | out_ready_i;
   assign in_ready_o  = en;
   assign tag_o       = tag_pipe[C_STAGES-1];

   // Valid shift register; bubbles travel like beats.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
      end else if (en) begin
         vld_pipe[0] <= in_valid_i;
         for (int i = 1; i < C_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // Tag pipeline, loaded only behind a valid beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < C_STAGES; i++) tag_pipe[i] <= '0;
      end else if (en) begin
         if (in_valid_i) tag_pipe[0] <= tag_i;
         for (int i = 1; i < C_STAGES; i++)
            if (vld_pipe[i-1]) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   // S0 operand capture, gated to accepted beats only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sub_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (en && in_valid_i) begin
         sub_q <= op_sub_i;
         a_q   <= operand_a_i;
         b_q   <= operand_b_i;
      end
   end

   generate
      if (C_STAGES >= 2) begin : g_ld_pre
         assign ld_pre = en & vld_pipe[0];
      end else begin : g_no_pre
         assign ld_pre = 1'b0;
      end
      if (C_STAGES == 3) begin : g_ld_res
         assign ld_res = en & vld_pipe[1];
      end else begin : g_no_res
         assign ld_res = 1'b0;
      end

      for (genvar k = 0; k < C_LANES; k++) begin : g_lane
         fp_adder_lane #(
            .C_OP(C_OP), .C_EXP(C_EXP), .C_MANT(C_MANT),
            .C_EXP_PRENORM(C_EXP_PRENORM), .C_MANT_PRENORM(C_MANT_PRENORM),
            .C_STAGES(C_STAGES)
         ) u_lane (
            .clk(clk_i), .rst_n(rst_ni), .ld_pre(ld_pre), .ld_res(ld_res),
            .op_sub(sub_q[k]),
            .a(a_q[k*C_OP +: C_OP]), .b(b_q[k*C_OP +: C_OP]),
            .result(result_o[k*C_OP +: C_OP])
         );
      end
   endgenerate

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Scoreboard bench for fp_adder_pipe: fp16, two lanes, three stages.
module tb_fp_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  op_sub = '0;
   logic [31:0] a = '0, b = '0, result;
   logic [3:0]  tag = '0, tag_out;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fp_adder_pipe #(
      .C_OP(16), .C_EXP(5), .C_MANT(10), .C_EXP_PRENORM(7), .C_MANT_PRENORM(12),
      .C_LANES(2), .C_STAGES(3), .C_TAG_W(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op_sub_i(op_sub), .operand_a_i(a), .operand_b_i(b), .tag_i(tag),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .result_o(result), .tag_o(tag_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pop the oldest expectation on every output handshake.
   always begin : monitor
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got tag %h result %h expected no beat", tag_out, result);
         end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("tag", 32'(tag_out), 32'(e.tag));
         end
      end
   end

   // Present one beat from a negedge, wait for acceptance, record expectation.
   task automatic issue(input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic [1:0] sub, input logic [3:0] t,
                        input logic [15:0] e0, input logic [15:0] e1);
      logic acc;
      exp_t x;
      acc      = 1'b0;
      in_valid = 1'b1;
      a        = {a1, a0};
      b        = {b1, b0};
      op_sub   = sub;
      tag      = t;
      for (int c = 0; c < 50 && !acc; c++) begin
         #1 acc = in_ready;
         @(posedge clk);
         if (acc) begin
            x.res = {e1, e0};
            x.tag = t;
            sb.push_back(x);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: tag %h not accepted, expected accept within 50 cycles", t);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 30 && sb.size() > 0; c++) @(negedge clk);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_tag", 32'(tag_out), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1 check("idle_no_out", 32'(out_valid), 32'd0);
      end
      @(negedge clk);

      // Single add/sub beat with latency check: 1+2=3, 3-1=2
      issue(16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 2'b10, 4'h5, 16'h4200, 16'h4000);
      #1 check("lat_s0", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 check("lat_s1", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 check("lat_s2", 32'(out_valid), 32'd1);
      @(negedge clk);
      drain();

      // Zero / cancellation: 0+0.5=0.5, 0.5-0.5=0
      issue(16'h0000, 16'h3800, 16'h3800, 16'h3800, 2'b10, 4'h6, 16'h3800, 16'h0000);
      drain();

      // Back-to-back stream, tags 0..7
      issue(16'h3C00, 16'h3C00, 16'h4000, 16'h3C00, 2'b10, 4'h0, 16'h4000, 16'h3C00);
      issue(16'h4000, 16'h4000, 16'h4400, 16'h3C00, 2'b10, 4'h1, 16'h4400, 16'h4200);
      issue(16'h3C00, 16'h3800, 16'h4200, 16'h3E00, 2'b10, 4'h2, 16'h3E00, 16'h3E00);
      issue(16'h4400, 16'h4400, 16'h3C00, 16'h4000, 2'b10, 4'h3, 16'h4800, 16'hBC00);
      issue(16'h3400, 16'h3400, 16'h4500, 16'h3C00, 2'b10, 4'h4, 16'h3800, 16'h4400);
      issue(16'h4600, 16'h4000, 16'h4200, 16'hBC00, 2'b10, 4'h5, 16'h4800, 16'h4400);
      issue(16'h3E00, 16'h3E00, 16'h4800, 16'h4800, 2'b10, 4'h6, 16'h4200, 16'h0000);
      issue(16'h0000, 16'h3800, 16'hBC00, 16'hBC00, 2'b00, 4'h7, 16'h3800, 16'hC000);
      drain();

      // Backpressure: fill the pipe, hold 5 cycles, then release
      out_ready = 1'b0;
      issue(16'h3C00, 16'h3C00, 16'h4400, 16'h3C00, 2'b00, 4'h8, 16'h4000, 16'h4500);
      issue(16'h3800, 16'h3800, 16'h4000, 16'h3800, 2'b10, 4'h9, 16'h3C00, 16'h3E00);
      issue(16'h4200, 16'h3C00, 16'h4500, 16'h4400, 2'b10, 4'hA, 16'h4400, 16'h3C00);
      in_valid = 1'b1;
      a        = {16'h4800, 16'h4600};
      b        = {16'h4000, 16'h4000};
      op_sub   = 2'b10;
      tag      = 4'hB;
      #1;
      for (int c = 0; c < 5; c++) begin
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_result", result, {16'h4500, 16'h4000});
         check("stall_tag", 32'(tag_out), 32'h8);
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      out_ready = 1'b1;
      issue(16'h4600, 16'h4000, 16'h4800, 16'h4000, 2'b10, 4'hB, 16'h4800, 16'h4600);
      drain();

      // Reset with three beats in flight
      out_ready = 1'b0;
      issue(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, 4'hC, 16'h4000, 16'h4000);
      issue(16'h4000, 16'h4000, 16'h4000, 16'h4000, 2'b00, 4'hD, 16'h4400, 16'h4400);
      issue(16'h4400, 16'h4400, 16'h4400, 16'h4400, 2'b00, 4'hE, 16'h4800, 16'h4800);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1 check("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      issue(16'h3C00, 16'h3800, 16'h4000, 16'h4000, 2'b00, 4'hF, 16'h3E00, 16'h4400);
      issue(16'hBC00, 16'h3C00, 16'h3C00, 16'hBC00, 2'b11, 4'h0, 16'hC000, 16'h4000);
      drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_adder_pipe.md
# fp_adder_pipe

Multi-lane, parametrised-depth floating-point adder/subtractor with valid/ready flow control. Each accepted beat carries `C_LANES` independent operand pairs, one add/sub select per lane, and a tag. Results leave in order after a fixed latency of `C_STAGES` cycles. The block sits between the operand/accumulation datapath and downstream consumers, and replaces the single-lane, always-enabled adder where backpressure or higher clock rates are required.

## Interface
- `C_OP`, `fp_defs::C_OP`, total float width
- `C_EXP`, `fp_defs::C_EXP`, exponent width
- `C_MANT`, `fp_defs::C_MANT`, stored mantissa width
- `C_EXP_PRENORM` / `C_MANT_PRENORM`, `fp_defs` values, pre-normalisation widths
- `C_LANES`, 4, parallel operand pairs per beat (≥1)
- `C_STAGES`, 2, pipeline depth in {1,2,3}
- `C_TAG_W`, 4, sideband tag width (≥1)
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `in_valid_i`  in  1  input beat valid
- `in_ready_o`  out  1  block accepts a beat this cycle
- `op_sub_i`  in  C_LANES  per lane: 1 = a−b, 0 = a+b
- `operand_a_i`  in  C_LANES*C_OP  lane k at `[k*C_OP +: C_OP]`
- `operand_b_i`  in  C_LANES*C_OP  same packing as `operand_a_i`
- `tag_i`  in  C_TAG_W  opaque sideband, returned unchanged
- `out_valid_o`  out  1  result beat valid
- `out_ready_i`  in  1  consumer accepts the result
- `result_o`  out  C_LANES*C_OP  per-lane results, same packing as the operands
- `tag_o`  out  C_TAG_W  tag of the result beat

## Operation
- **Per lane:**
  - Unpack sign, exponent and mantissa.
  - Hidden bit = OR of exponent bits, so a zero exponent is treated as denormal/zero.
  - For subtraction, b's sign is inverted before the add core.
  - Add core produces a pre-normalised sign, exponent and mantissa; the normaliser produces the final exponent and mantissa.
  - Result = {prenorm sign, normalised exp, mant[C_MANT-1:0]}.
  - Rounding, overflow and special values behave exactly as the existing add/norm cores; no new rounding.
- **Stage mapping:**
  - S0 always registers operands, op_sub, tag and valid.
  - `C_STAGES=1`: add and norm both combinational after S0.
  - `C_STAGES=2`: register after the add core (prenorm sign/exp/mant).
  - `C_STAGES=3`: additionally register the final result.
- **Flow control:**
  - Global enable `en = ~out_valid_o | out_ready_i`; `in_ready_o = en`.
  - When `en=1`, every stage's valid and data advance one stage. S0 loads `in_valid_i & in_ready_o`.
  - When `en=0`, all stage registers hold.
  - Bubbles are not collapsed.
- **Data gating:** data registers load only when `en` is high and the incoming valid is 1. Otherwise they hold, which saves toggling.

## Timing
- **Reset:**
  - All stage valids and data/tag registers are 0.
  - `out_valid_o=0`, `result_o=0`, `tag_o=0`, `in_ready_o=1`.
- **Latency:** a beat accepted at edge N appears with `out_valid_o=1` at edge N+C_STAGES−1, i.e. in the cycle after S(C_STAGES−1) loads. With no stalls, throughput is 1 beat/cycle.
- **Output stability:** `out_valid_o`, `result_o` and `tag_o` stay stable while `out_valid_o & ~out_ready_i`.
- **Simultaneous events:** accept and emit in the same cycle are legal and are the steady-state behaviour.
- **Stall:** with `out_ready_i=0` and output valid, `in_ready_o` drops combinationally in the same cycle. `in_valid_i` is ignored while `in_ready_o=0`.
- **Reset mid-operation:** asynchronous assert clears all in-flight beats immediately; nothing is emitted afterwards.

## Structure
- **`fp_defs` package:**
  - Holds the default widths.
  - Add a packed `fp_lane_t` struct {sign, exp, mant} and a `prenorm_t` struct {sign, exp signed C_EXP_PRENORM, mant C_MANT_PRENORM}.
- **Sub-module `fp_adder_lane`:**
  - One per lane, generated `C_LANES` times.
  - Contains unpack, sub-inversion, `fp_add`, the optional prenorm register and `fp_norm`, with an enable input.
  - Valid/tag control lives once in the top module.

## Test plan
Bench uses fp16 (C_OP=16, C_EXP=5, C_MANT=10), C_LANES=2, C_STAGES=3.
- **Reset:** assert `rst_ni` low → `out_valid_o=0`, `result_o=0`, `in_ready_o=1`; release, no output without input.
- **Add/sub per lane:** lane0 0x3C00+0x4000 add, lane1 0x4200−0x3C00 sub, tag 0x5 → after 3 cycles result lane0 0x4200, lane1 0x4000, tag 0x5.
- **Back-to-back:** stream 8 beats with tags 0..7, `out_ready_i=1` → outputs tags 0..7 on consecutive cycles with correct sums.
- **Backpressure:** hold `out_ready_i=0` for 5 cycles with the pipe full → `in_ready_o=0`, output held stable. On release, no beat is lost or duplicated.
- **Zero/denormal:** 0x0000+0x3800 → 0x3800; 0x3800−0x3800 → exponent and mantissa 0.
- **Reset mid-stream:** pulse `rst_ni` low with 3 beats in flight → `out_valid_o` drops immediately, and only post-reset beats are emitted.
